// File: rtl/soml_pkg.sv
// Shared definitions for the SOML frame loader: default geometry, write-FSM
// state encoding and the saturating negate used when conjugating Y.
package soml_pkg;

    localparam int DEF_N      = 32;
    localparam int DEF_NR     = 4;
    localparam int DEF_NT     = 4;
    localparam int DEF_NY     = 8;
    localparam int DEF_CONJ_Y = 1;

    localparam int H_ELEMS = DEF_NR * DEF_NT;
    localparam int Y_HALF  = DEF_NY / 2;
    localparam int H_CNT_W = $clog2(H_ELEMS + 1);
    localparam int Y_CNT_W = $clog2(DEF_NY + 1);
    localparam int ROW_W   = $clog2(DEF_NR);
    localparam int COL_W   = $clog2(DEF_NT);
    localparam int Y_IDX_W = $clog2(Y_HALF);

    typedef enum logic {
        W_LOAD = 1'b0,
        W_WAIT = 1'b1
    } wr_state_t;

    // x holds a w-bit two's-complement value sign-extended to 64 bits;
    // the most negative w-bit value maps to the most positive one.
    function automatic logic [63:0] sat_neg(input logic [63:0] x, input int unsigned w);
        logic [63:0] most_neg;
        most_neg = {64{1'b1}} << (w - 1);
        return (x == most_neg) ? ~most_neg : (~x + 64'd1);
    endfunction

endpackage

// File: rtl/soml_cplx_bank.sv
// One frame bank: H matrix and two Y halves as register arrays, single write
// port per array and registered random read.
module soml_cplx_bank
    import soml_pkg::*;
#(
    parameter int N  = 32,
    parameter int NR = 4,
    parameter int NT = 4,
    parameter int YH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    h_we,
    input  logic [$clog2(NR)-1:0]   h_wrow,
    input  logic [$clog2(NT)-1:0]   h_wcol,
    input  logic [N-1:0]            h_wr,
    input  logic [N-1:0]            h_wi,
    input  logic                    y_we,
    input  logic                    y_whalf,
    input  logic [$clog2(YH)-1:0]   y_widx,
    input  logic [N-1:0]            y_wr,
    input  logic [N-1:0]            y_wi,
    input  logic [$clog2(NR)-1:0]   h_rrow,
    input  logic [$clog2(NT)-1:0]   h_rcol,
    input  logic                    y_rhalf,
    input  logic [$clog2(YH)-1:0]   y_ridx,
    output logic [N-1:0]            h_rr,
    output logic [N-1:0]            h_ri,
    output logic [N-1:0]            y_rr,
    output logic [N-1:0]            y_ri
);

    logic [N-1:0] h_re [NR][NT];
    logic [N-1:0] h_im [NR][NT];
    logic [N-1:0] y_re [2][YH];
    logic [N-1:0] y_im [2][YH];

    // Storage carries no reset; contents are meaningless until a frame lands.
    always_ff @(posedge clk) begin
        if (h_we) begin
            h_re[h_wrow][h_wcol] <= h_wr;
            h_im[h_wrow][h_wcol] <= h_wi;
        end
        if (y_we) begin
            y_re[y_whalf][y_widx] <= y_wr;
            y_im[y_whalf][y_widx] <= y_wi;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_rr <= '0;
            h_ri <= '0;
            y_rr <= '0;
            y_ri <= '0;
        end else begin
            h_rr <= h_re[h_rrow][h_rcol];
            h_ri <= h_im[h_rrow][h_rcol];
            y_rr <= y_re[y_rhalf][y_ridx];
            y_ri <= y_im[y_rhalf][y_ridx];
        end
    end

endmodule

// File: rtl/soml_frame_loader.sv
// Ping-pong input store for the SOML decoder: one bank fills from the H/Y
// streams while the other is served to the decoder until frame_release.
//
// state  | meaning
// W_LOAD | write bank accepting H/Y; completes into the other bank if it is empty
// W_WAIT | write bank full, read bank busy; both readies held low
module soml_frame_loader
    import soml_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int NR     = DEF_NR,
    parameter int NT     = DEF_NT,
    parameter int NY     = DEF_NY,
    parameter int CONJ_Y = DEF_CONJ_Y
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      H_in_valid,
    output logic                      H_in_ready,
    input  logic [N-1:0]              H_in_r,
    input  logic [N-1:0]              H_in_i,
    input  logic                      Y_in_valid,
    output logic                      Y_in_ready,
    input  logic [N-1:0]              Y_in_r,
    input  logic [N-1:0]              Y_in_i,
    output logic                      frame_start,
    output logic                      frame_ready,
    input  logic [$clog2(NR)-1:0]     rd_h_row,
    input  logic [$clog2(NT)-1:0]     rd_h_col,
    output logic [N-1:0]              rd_h_r,
    output logic [N-1:0]              rd_h_i,
    input  logic                      rd_y_half,
    input  logic [$clog2(NY/2)-1:0]   rd_y_idx,
    output logic [N-1:0]              rd_y_r,
    output logic [N-1:0]              rd_y_i,
    input  logic                      frame_release,
    output logic                      rd_bank,
    output logic [15:0]               frames_done
);

    localparam int H_TOT      = NR * NT;
    localparam int Y_PER_HALF = NY / 2;
    localparam int HCW        = $clog2(H_TOT + 1);
    localparam int YCW        = $clog2(NY + 1);
    localparam int RW         = $clog2(NR);
    localparam int CW         = $clog2(NT);
    localparam int YIW        = $clog2(Y_PER_HALF);

    localparam logic [HCW-1:0] H_FULL = HCW'(H_TOT);
    localparam logic [HCW-1:0] NT_W   = HCW'(NT);
    localparam logic [YCW-1:0] Y_FULL = YCW'(NY);
    localparam logic [YCW-1:0] YH_W   = YCW'(Y_PER_HALF);

    wr_state_t        wr_state, wr_state_n;
    logic             wr_bank, wr_bank_n;
    logic [HCW-1:0]   h_cnt, h_cnt_n, h_inc;
    logic [YCW-1:0]   y_cnt, y_cnt_n, y_inc;
    logic [1:0]       full, full_n, full_rel, set_full;
    logic             run;
    logic             h_acc, y_acc, rel, active_rel;
    logic             rd_bank_n, frame_start_n, frame_ready_n;

    logic [RW-1:0]    h_wrow;
    logic [CW-1:0]    h_wcol;
    logic             y_whalf;
    logic [YIW-1:0]   y_widx;
    logic [N-1:0]     y_wi;

    logic [N-1:0]     bank_hr [2];
    logic [N-1:0]     bank_hi [2];
    logic [N-1:0]     bank_yr [2];
    logic [N-1:0]     bank_yi [2];

    // run keeps the readies low for the whole reset and releases them one cycle later.
    assign H_in_ready = run && (wr_state == W_LOAD) && (h_cnt < H_FULL) && !start;
    assign Y_in_ready = run && (wr_state == W_LOAD) && (y_cnt < Y_FULL) && !start;
    assign h_acc      = H_in_valid && H_in_ready;
    assign y_acc      = Y_in_valid && Y_in_ready;
    assign h_inc      = h_cnt + HCW'(h_acc);
    assign y_inc      = y_cnt + YCW'(y_acc);

    assign h_wrow  = RW'(h_cnt / NT_W);
    assign h_wcol  = CW'(h_cnt % NT_W);
    assign y_whalf = (y_cnt >= YH_W);
    assign y_widx  = YIW'(y_cnt % YH_W);
    assign y_wi    = (CONJ_Y != 0) ? N'(sat_neg(64'(signed'(Y_in_i)), N)) : Y_in_i;

    always_comb begin
        wr_state_n = wr_state;
        wr_bank_n  = wr_bank;
        h_cnt_n    = h_cnt;
        y_cnt_n    = y_cnt;
        set_full   = 2'b00;
        rel        = frame_release && frame_ready;
        full_rel   = full;
        if (rel) begin
            full_rel[rd_bank] = 1'b0;
        end

        // A release in the same cycle already counts as freeing the other bank.
        case (wr_state)
            W_LOAD: begin
                if (start) begin
                    h_cnt_n = '0;
                    y_cnt_n = '0;
                end else begin
                    h_cnt_n = h_inc;
                    y_cnt_n = y_inc;
                    if (h_inc == H_FULL && y_inc == Y_FULL) begin
                        set_full[wr_bank] = 1'b1;
                        if (!full_rel[~wr_bank]) begin
                            wr_bank_n = ~wr_bank;
                            h_cnt_n   = '0;
                            y_cnt_n   = '0;
                        end else begin
                            wr_state_n = W_WAIT;
                        end
                    end
                end
            end
            W_WAIT: begin
                if (!full_rel[~wr_bank]) begin
                    wr_bank_n  = ~wr_bank;
                    h_cnt_n    = '0;
                    y_cnt_n    = '0;
                    wr_state_n = W_LOAD;
                end
            end
            default: wr_state_n = W_LOAD;
        endcase

        full_n        = full_rel | set_full;
        active_rel    = frame_ready && !rel;
        rd_bank_n     = rd_bank;
        frame_start_n = 1'b0;
        // The other bank is always the older waiting frame, so it wins.
        if (!active_rel) begin
            if (full_n[~rd_bank]) begin
                rd_bank_n     = ~rd_bank;
                frame_start_n = 1'b1;
            end else if (full_n[rd_bank]) begin
                frame_start_n = 1'b1;
            end
        end
        frame_ready_n = active_rel || frame_start_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state    <= W_LOAD;
            wr_bank     <= 1'b0;
            h_cnt       <= '0;
            y_cnt       <= '0;
            full        <= 2'b00;
            run         <= 1'b0;
            rd_bank     <= 1'b0;
            frame_start <= 1'b0;
            frame_ready <= 1'b0;
            frames_done <= '0;
        end else begin
            wr_state    <= wr_state_n;
            wr_bank     <= wr_bank_n;
            h_cnt       <= h_cnt_n;
            y_cnt       <= y_cnt_n;
            full        <= full_n;
            run         <= 1'b1;
            rd_bank     <= rd_bank_n;
            frame_start <= frame_start_n;
            frame_ready <= frame_ready_n;
            frames_done <= frames_done + 16'(rel);
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        soml_cplx_bank #(
            .N  (N),
            .NR (NR),
            .NT (NT),
            .YH (Y_PER_HALF)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .h_we    (h_acc && (wr_bank == 1'(b))),
            .h_wrow  (h_wrow),
            .h_wcol  (h_wcol),
            .h_wr    (H_in_r),
            .h_wi    (H_in_i),
            .y_we    (y_acc && (wr_bank == 1'(b))),
            .y_whalf (y_whalf),
            .y_widx  (y_widx),
            .y_wr    (Y_in_r),
            .y_wi    (y_wi),
            .h_rrow  (rd_h_row),
            .h_rcol  (rd_h_col),
            .y_rhalf (rd_y_half),
            .y_ridx  (rd_y_idx),
            .h_rr    (bank_hr[b]),
            .h_ri    (bank_hi[b]),
            .y_rr    (bank_yr[b]),
            .y_ri    (bank_yi[b])
        );
    end

    assign rd_h_r = bank_hr[rd_bank];
    assign rd_h_i = bank_hi[rd_bank];
    assign rd_y_r = bank_yr[rd_bank];
    assign rd_y_i = bank_yi[rd_bank];

endmodule

// File: tb/tb_soml_frame_loader.sv
// Directed-plus-random bench for soml_frame_loader: a default 4x4/8 conjugating
// instance and a 2x2/4 pass-through instance, checked against per-frame arrays.
module tb_soml_frame_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, h_v, y_v, rel;
    logic [31:0] h_r, h_i, y_r, y_i;
    logic [1:0]  rrow, rcol, ridx;
    logic        rhalf;
    logic        h_rdy, y_rdy, fs, fr, rb;
    logic [31:0] o_hr, o_hi, o_yr, o_yi;
    logic [15:0] fd;

    logic        s_start, s_hv, s_yv, s_rel;
    logic [31:0] s_hr_in, s_hi_in, s_yr_in, s_yi_in;
    logic        s_rrow, s_rcol, s_rhalf, s_ridx;
    logic        s_h_rdy, s_y_rdy, s_fs, s_fr, s_rb;
    logic [31:0] s_ohr, s_ohi, s_oyr, s_oyi;
    logic [15:0] s_fd;

    soml_frame_loader u_dut (
        .clk(clk), .rst(rst), .start(start),
        .H_in_valid(h_v), .H_in_ready(h_rdy), .H_in_r(h_r), .H_in_i(h_i),
        .Y_in_valid(y_v), .Y_in_ready(y_rdy), .Y_in_r(y_r), .Y_in_i(y_i),
        .frame_start(fs), .frame_ready(fr),
        .rd_h_row(rrow), .rd_h_col(rcol), .rd_h_r(o_hr), .rd_h_i(o_hi),
        .rd_y_half(rhalf), .rd_y_idx(ridx), .rd_y_r(o_yr), .rd_y_i(o_yi),
        .frame_release(rel), .rd_bank(rb), .frames_done(fd)
    );

    soml_frame_loader #(.N(32), .NR(2), .NT(2), .NY(4), .CONJ_Y(0)) u_sml (
        .clk(clk), .rst(rst), .start(s_start),
        .H_in_valid(s_hv), .H_in_ready(s_h_rdy), .H_in_r(s_hr_in), .H_in_i(s_hi_in),
        .Y_in_valid(s_yv), .Y_in_ready(s_y_rdy), .Y_in_r(s_yr_in), .Y_in_i(s_yi_in),
        .frame_start(s_fs), .frame_ready(s_fr),
        .rd_h_row(s_rrow), .rd_h_col(s_rcol), .rd_h_r(s_ohr), .rd_h_i(s_ohi),
        .rd_y_half(s_rhalf), .rd_y_idx(s_ridx), .rd_y_r(s_oyr), .rd_y_i(s_oyi),
        .frame_release(s_rel), .rd_bank(s_rb), .frames_done(s_fd)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int fs_cnt  = 0;

    // frame contents as sent, indexed by frame number
    logic [31:0] m_hr [8][16];
    logic [31:0] m_hi [8][16];
    logic [31:0] m_yr [8][8];
    logic [31:0] m_yi [8][8];
    logic [31:0] s_hr [4];
    logic [31:0] s_hi [4];
    logic [31:0] s_yr [4];
    logic [31:0] s_yi [4];

    always @(negedge clk) if (fs === 1'b1) fs_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] conj_i(input logic [31:0] v);
        longint s;
        s = -longint'($signed(v));
        if (s > 64'sd2147483647) s = 64'sd2147483647;
        return s[31:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic gen_frame(input int f, input bit pattern);
        for (int k = 0; k < 16; k++) begin
            m_hr[f][k] = pattern ? 32'(k + 1) : $urandom;
            m_hi[f][k] = pattern ? -32'(k + 1) : $urandom;
        end
        for (int j = 0; j < 8; j++) begin
            m_yr[f][j] = pattern ? 32'(100 + j) : $urandom;
            m_yi[f][j] = pattern ? -32'(200 + j) : $urandom;
        end
    endtask

    // Entered and left at a negedge; inputs change only on negedges.
    task automatic load(input int f, input int h_lim, input int y_lim, input int y_every,
                        input int budget, output int h_n, output int y_n);
        bit ht, yt;
        h_n = 0;
        y_n = 0;
        for (int c = 0; c < budget && (h_n < h_lim || y_n < y_lim); c++) begin
            h_v = (h_n < h_lim);
            if (h_n < h_lim) begin
                h_r = m_hr[f][h_n];
                h_i = m_hi[f][h_n];
            end
            y_v = (y_n < y_lim) && (c % y_every == 0);
            if (y_n < y_lim) begin
                y_r = m_yr[f][y_n];
                y_i = m_yi[f][y_n];
            end
            #1;
            ht = h_v && h_rdy;
            yt = y_v && y_rdy;
            @(negedge clk);
            h_n += int'(ht);
            y_n += int'(yt);
        end
        h_v = 1'b0;
        y_v = 1'b0;
    endtask

    task automatic release_pulse();
        rel = 1'b1;
        @(negedge clk);
        rel = 1'b0;
    endtask

    task automatic rd_h(input int f, input int k, input string tag);
        rrow = 2'(k / 4);
        rcol = 2'(k % 4);
        @(negedge clk);
        chk({tag, "_hr"}, o_hr, m_hr[f][k]);
        chk({tag, "_hi"}, o_hi, m_hi[f][k]);
    endtask

    task automatic rd_y(input int f, input int j, input string tag);
        rhalf = (j >= 4);
        ridx  = 2'(j % 4);
        @(negedge clk);
        chk({tag, "_yr"}, o_yr, m_yr[f][j]);
        chk({tag, "_yi"}, o_yi, conj_i(m_yi[f][j]));
    endtask

    initial begin
        int hn, yn, snap;
        bit drop_seen, ht, yt;
        rst = 1'b1; start = 1'b0; h_v = 1'b0; y_v = 1'b0; rel = 1'b0;
        h_r = '0; h_i = '0; y_r = '0; y_i = '0;
        rrow = '0; rcol = '0; rhalf = 1'b0; ridx = '0;
        s_start = 1'b0; s_hv = 1'b0; s_yv = 1'b0; s_rel = 1'b0;
        s_hr_in = '0; s_hi_in = '0; s_yr_in = '0; s_yi_in = '0;
        s_rrow = 1'b0; s_rcol = 1'b0; s_rhalf = 1'b0; s_ridx = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_h_ready", 32'(h_rdy), 0);
        chk("rst_y_ready", 32'(y_rdy), 0);
        chk("rst_frame_start", 32'(fs), 0);
        chk("rst_frame_ready", 32'(fr), 0);
        chk("rst_rd_bank", 32'(rb), 0);
        chk("rst_frames_done", 32'(fd), 0);
        chk("rst_rd_h_r", o_hr, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_h_ready", 32'(h_rdy), 1);
        chk("post_rst_y_ready", 32'(y_rdy), 1);

        // 1: patterned frame, Y every other cycle
        gen_frame(0, 1'b1);
        load(0, 16, 8, 2, 200, hn, yn);
        chk("t1_h_taken", hn, 16);
        chk("t1_y_taken", yn, 8);
        chk("t1_frame_start", 32'(fs), 1);
        chk("t1_rd_bank", 32'(rb), 0);
        @(negedge clk);
        chk("t1_one_pulse", fs_cnt, 1);
        chk("t1_frame_ready", 32'(fr), 1);
        rrow = 2'd2; rcol = 2'd3;
        @(negedge clk);
        chk("t1_h23_r", o_hr, 32'd12);
        chk("t1_h23_i", o_hi, 32'hFFFF_FFF4);
        rhalf = 1'b1; ridx = 2'd1;
        @(negedge clk);
        chk("t1_y5_r", o_yr, 32'd105);
        chk("t1_y5_i", o_yi, 32'd205);
        for (int i = 0; i < 3; i++) rd_h(0, int'($urandom_range(0, 15)), "t1_rand");

        // 2: second frame fills the other bank, a third one stalls
        gen_frame(1, 1'b0);
        load(1, 16, 8, 1, 200, hn, yn);
        chk("t2_b_taken", hn + yn, 24);
        chk("t2_h_ready_low", 32'(h_rdy), 0);
        chk("t2_y_ready_low", 32'(y_rdy), 0);
        chk("t2_rd_bank_hold", 32'(rb), 0);
        gen_frame(2, 1'b0);
        load(2, 16, 8, 1, 10, hn, yn);
        chk("t2_stall_taken", hn + yn, 0);
        chk("t2_fs_count", fs_cnt, 1);
        release_pulse();
        chk("t2_rd_bank", 32'(rb), 1);
        chk("t2_frame_start", 32'(fs), 1);
        chk("t2_frames_done", 32'(fd), 1);
        chk("t2_h_ready_back", 32'(h_rdy), 1);
        chk("t2_y_ready_back", 32'(y_rdy), 1);
        for (int i = 0; i < 3; i++) rd_h(1, int'($urandom_range(0, 15)), "t2_rand");
        for (int i = 0; i < 2; i++) rd_y(1, int'($urandom_range(0, 7)), "t2_rand");

        // 3: most negative imag saturates when conjugated
        m_yi[2][0] = 32'h8000_0000;
        m_yi[2][7] = 32'h8000_0000;
        load(2, 16, 8, 1, 200, hn, yn);
        chk("t3_taken", hn + yn, 24);
        release_pulse();
        chk("t3_rd_bank", 32'(rb), 0);
        chk("t3_frames_done", 32'(fd), 2);
        rhalf = 1'b0; ridx = 2'd0;
        @(negedge clk);
        chk("t3_sat_y0_i", o_yi, 32'h7FFF_FFFF);
        rd_y(2, 7, "t3_y7");
        rd_y(2, int'($urandom_range(1, 6)), "t3_rand");
        rd_h(2, int'($urandom_range(0, 15)), "t3_rand");

        // 4: start discards a partial frame
        release_pulse();
        chk("t4_frame_ready_low", 32'(fr), 0);
        chk("t4_frames_done", 32'(fd), 3);
        gen_frame(5, 1'b0);
        gen_frame(3, 1'b0);
        load(5, 7, 3, 1, 50, hn, yn);
        chk("t4_partial_taken", hn * 100 + yn, 703);
        start = 1'b1; h_v = 1'b1; y_v = 1'b1;
        #1;
        chk("t4_start_h_ready", 32'(h_rdy), 0);
        chk("t4_start_y_ready", 32'(y_rdy), 0);
        @(negedge clk);
        start = 1'b0; h_v = 1'b0; y_v = 1'b0;
        snap = fs_cnt;
        load(3, 16, 8, 1, 200, hn, yn);
        chk("t4_taken", hn + yn, 24);
        repeat (2) @(negedge clk);
        chk("t4_one_pulse", fs_cnt - snap, 1);
        chk("t4_rd_bank", 32'(rb), 1);
        for (int k = 0; k < 16; k++) rd_h(3, k, "t4_all");
        for (int j = 0; j < 8; j++) rd_y(3, j, "t4_all");

        // 5: last Y accepted together with release
        gen_frame(4, 1'b0);
        load(4, 16, 7, 1, 200, hn, yn);
        chk("t5_pre_taken", hn + yn, 23);
        y_v = 1'b1; y_r = m_yr[4][7]; y_i = m_yi[4][7]; rel = 1'b1;
        #1;
        yt = y_rdy;
        chk("t5_y_ready", 32'(yt), 1);
        @(negedge clk);
        y_v = 1'b0; rel = 1'b0;
        chk("t5_frame_start", 32'(fs), 1);
        chk("t5_frames_done", 32'(fd), 4);
        chk("t5_rd_bank", 32'(rb), 0);
        chk("t5_frame_ready", 32'(fr), 1);
        rd_y(4, 7, "t5_y7");
        rd_h(4, int'($urandom_range(0, 15)), "t5_rand");
        release_pulse();
        chk("t5_frames_done2", 32'(fd), 5);
        chk("t5_idle", 32'(fr), 0);
        release_pulse();
        chk("t5_idle_release", 32'(fd), 5);

        // reset in the middle of a frame
        gen_frame(6, 1'b0);
        load(6, 16, 8, 1, 5, hn, yn);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        snap = fs_cnt;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_start", fs_cnt - snap, 0);
        chk("rst_mid_frames_done", 32'(fd), 0);
        chk("rst_mid_frame_ready", 32'(fr), 0);

        // 6: small geometry, no conjugation
        for (int k = 0; k < 4; k++) begin
            s_hr[k] = $urandom; s_hi[k] = $urandom;
            s_yr[k] = $urandom; s_yi[k] = $urandom;
        end
        s_yi[1] = 32'h8000_0000;
        hn = 0; yn = 0; drop_seen = 1'b0;
        for (int c = 0; c < 40 && (hn < 4 || yn < 4); c++) begin
            s_hv = (hn < 4);
            if (hn < 4) begin s_hr_in = s_hr[hn]; s_hi_in = s_hi[hn]; end
            s_yv = (yn < 4) && (c % 2 == 0);
            if (yn < 4) begin s_yr_in = s_yr[yn]; s_yi_in = s_yi[yn]; end
            #1;
            if (hn == 4 && !drop_seen) begin
                drop_seen = 1'b1;
                chk("t6_h_ready_drop", 32'(s_h_rdy), 0);
            end
            ht = s_hv && s_h_rdy;
            yt = s_yv && s_y_rdy;
            @(negedge clk);
            hn += int'(ht);
            yn += int'(yt);
        end
        s_hv = 1'b0; s_yv = 1'b0;
        chk("t6_taken", hn * 10 + yn, 44);
        chk("t6_frame_start", 32'(s_fs), 1);
        chk("t6_h_ready_next", 32'(s_h_rdy), 1);
        for (int k = 0; k < 4; k++) begin
            s_rrow = (k >= 2);
            s_rcol = k[0];
            s_rhalf = (k >= 2);
            s_ridx = k[0];
            @(negedge clk);
            chk("t6_hr", s_ohr, s_hr[k]);
            chk("t6_hi", s_ohi, s_hi[k]);
            chk("t6_yr", s_oyr, s_yr[k]);
            chk("t6_yi", s_oyi, s_yi[k]);
        end
        s_rhalf = 1'b0; s_ridx = 1'b1;
        @(negedge clk);
        chk("t6_noconj_min", s_oyi, 32'h8000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/soml_frame_loader.md
Name: soml_frame_loader

Overview:
- Parametrised, double-buffered (ping-pong) input store for the SOML decoder.
- Accepts one NR x NT complex channel matrix H and NY complex received samples Y per frame through valid/ready streams, in any interleaving.
- Announces each completed frame to the Hq/trace pipeline and serves registered random reads from the bank being decoded. Frame k+1 loads while frame k is being decoded.

Parameters:
N, 32, sample word width (signed fixed point, two's complement)
NR, 4, H rows (receive antennas)
NT, 4, H columns
NY, 8, Y samples per frame (first NY/2 go to Y half 0, the rest to Y half 1)
CONJ_Y, 1, 1 = store conj(Y) (imaginary part negated); 0 = store as received

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  discard any partial frame in the write bank and restart its counters
H_in_valid  in  1  H element valid, row-major order
H_in_ready  out  1  H element accepted when valid & ready
H_in_r, H_in_i  in  N  H element real/imag
Y_in_valid  in  1  Y sample valid, index order 0..NY-1
Y_in_ready  out  1  Y sample accepted when valid & ready
Y_in_r, Y_in_i  in  N  Y sample real/imag
frame_start  out  1  one-cycle pulse: a bank became the read bank
frame_ready  out  1  read bank holds a complete frame
rd_h_row  in  clog2(NR)  H read row
rd_h_col  in  clog2(NT)  H read column
rd_h_r, rd_h_i  out  N  H read data, 1-cycle latency
rd_y_half  in  1  Y half select
rd_y_idx  in  clog2(NY/2)  Y index within half
rd_y_r, rd_y_i  out  N  Y read data, 1-cycle latency
frame_release  in  1  downstream finished with read bank
rd_bank  out  1  current read bank id
frames_done  out  16  count of released frames, wraps

Behaviour:
- Reset: all outputs 0. H_in_ready and Y_in_ready become 1 in the first cycle after rst deasserts. Both banks empty; wr_bank=0, rd_bank=0. Memory contents are don't-care.

Write side FSM:
- W_LOAD:
  - Accepts H while h_cnt < NR*NT and Y while y_cnt < NY.
  - Each ready drops individually once its count is complete.
  - When both counts are complete, the write bank is marked full.
  - If the other bank is empty: toggle wr_bank, clear counts, stay in W_LOAD.
  - Otherwise go to W_WAIT.
- W_WAIT: both readies 0. When a bank frees: toggle wr_bank, clear counts, return to W_LOAD.
- start:
  - In W_LOAD it clears h_cnt/y_cnt and overrides acceptance that same cycle; no element is written.
  - In W_WAIT it is ignored.
  - Full banks are never touched by start.

Store rules:
- H is written at [h_cnt/NT][h_cnt%NT].
- Y index j writes half j/(NY/2), slot j%(NY/2).
- With CONJ_Y=1, the stored imag is -Y_in_i, saturated: -(-2^(N-1)) stores 2^(N-1)-1.

Read side:
- frame_start pulses the cycle after a bank becomes full, if no frame is active; otherwise the cycle after frame_release.
- frame_ready stays high from that pulse until frame_release.
- frame_release:
  - Marks the read bank empty and increments frames_done.
  - Moves rd_bank to the other bank if that bank is full, pulsing frame_start next cycle.
  - Ignored when frame_ready=0.
- Same-cycle completion and release: the release is processed first, so the completed bank becomes the read bank with frame_start next cycle. No frame is lost or duplicated.
- Read data is registered from the rd_bank copy. Reads with frame_ready=0 return stale/undefined data, and the bench does not check them.
- rst mid-frame drops everything; no frame_start follows.

Decomposition:
- Package soml_pkg:
  - localparams H_ELEMS=NR*NT, Y_HALF=NY/2, and the count/index widths.
  - Write-FSM state encoding (W_LOAD, W_WAIT).
  - Saturating-negate function.
- Sub-module soml_cplx_bank: one bank's H and Y register arrays, with write port and registered read port. Instantiated twice, with output mux on rd_bank.

Test Plan:
1. Default params. Stream H=k+1 (real) / -(k+1) (imag) for k=0..15, with Y interleaved 1 element per 2 cycles. → frame_start pulses once. Reading (2,3) returns 12/-12. Y[5] reads as half 1, idx 1, with imag negated.
2. Load frames A and B back-to-back without release. → Both readies drop after B; a third frame stalls. Release A → rd_bank=1, frame_start next cycle, readies reassert, frames_done=1.
3. Y_in_i=0x80000000 with CONJ_Y=1. → stored imag reads 0x7FFFFFFF. With CONJ_Y=0 it reads 0x80000000.
4. start after 7 H and 3 Y elements, then a full frame with new values. → No stale values are read. Exactly one frame_start.
5. Last Y element is accepted in the same cycle as frame_release, with the other bank empty. → frame_start next cycle and frames_done increments by 1. Release with frame_ready=0 leaves frames_done unchanged.
6. NR=2, NT=2, NY=4. → Readies drop after 4 H and 4 Y elements; all readbacks are correct.
